// File: rtl/apx_fmul_pkg.sv
// apx_fmul_pkg: shared FSM state type and float constants for the multiplier arbiter
package apx_fmul_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RESP   = 3'd4
  } state_t;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
endpackage

// File: rtl/apx_fmul_arbiter_if.sv
// apx_fmul_arbiter_if: requester and multiplier handshake bundle
interface apx_fmul_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [31:0]          rsp_z;
  logic [31:0]          mul_a;
  logic                 mul_a_stb;
  logic                 mul_a_ack;
  logic [31:0]          mul_b;
  logic                 mul_b_stb;
  logic                 mul_b_ack;
  logic [31:0]          mul_z;
  logic                 mul_z_stb;
  logic                 mul_z_ack;
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
    output req_ready, rsp_valid, rsp_z, mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack
  );
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
    input  req_ready, rsp_valid, rsp_z, mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack
  );
endinterface

// File: rtl/apx_rr_arbiter.sv
// apx_rr_arbiter: combinational round-robin pick, searching from i_ptr upward modulo NREQ
module apx_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);
  int w_j;
  // Walk from farthest to nearest so the requester closest to i_ptr wins last
  always_comb begin
    w_j = 0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (i_valid[w_j]) begin
        o_idx = IDW'(w_j);
        o_any = 1'b1;
      end
    end
    o_onehot = o_any ? (NREQ'(1) << o_idx) : '0;
  end
endmodule

// File: rtl/apx_fmul_arbiter.sv
// apx_fmul_arbiter: shares one float multiplier among NREQ requesters, round-robin, one op in flight
module apx_fmul_arbiter
  import apx_fmul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  apx_fmul_arbiter_if.slave   bus,
  output logic                busy,
  output logic [IDW-1:0]      grant_id,
  output logic [CNTW-1:0]     ops_done,
  output logic                err_stale
);
  state_t                  r_state;
  logic [IDW-1:0]          r_ptr;
  logic [IDW-1:0]          r_grant;
  logic [CNTW-1:0]         r_ops;
  logic [31:0]             r_opa;
  logic [31:0]             r_opb;
  logic [31:0]             r_zr;
  logic                    r_err;
  logic [NREQ-1:0]         w_onehot;
  logic [IDW-1:0]          w_idx;
  logic                    w_any;
  logic [NREQ-1:0][31:0]   w_av;
  logic [NREQ-1:0][31:0]   w_bv;
  logic                    w_idle;

  apx_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .i_valid  (bus.req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // Gate on rst_n so nothing handshakes while reset is held
  always_comb begin
    w_av          = bus.req_a;
    w_bv          = bus.req_b;
    w_idle        = (r_state == IDLE) && rst_n;
    bus.req_ready = w_idle ? w_onehot : '0;
    bus.mul_a_stb = (r_state == SEND_A);
    bus.mul_b_stb = (r_state == SEND_B);
    bus.mul_z_ack = w_idle || (r_state == WAIT_Z);
    bus.rsp_valid = (r_state == RESP) ? (NREQ'(1) << r_grant) : '0;
    bus.mul_a     = r_opa;
    bus.mul_b     = r_opb;
    bus.rsp_z     = r_zr;
    busy          = (r_state != IDLE);
    grant_id      = r_grant;
    ops_done      = r_ops;
    err_stale     = r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_ops   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_zr    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && bus.mul_z_stb;
      case (r_state)
        IDLE: if (w_any) begin
          r_opa   <= w_av[w_idx];
          r_opb   <= w_bv[w_idx];
          r_grant <= w_idx;
          r_state <= SEND_A;
        end
        SEND_A: if (bus.mul_a_ack) r_state <= SEND_B;
        SEND_B: if (bus.mul_b_ack) r_state <= WAIT_Z;
        WAIT_Z: if (bus.mul_z_stb) begin
          r_zr    <= bus.mul_z;
          r_state <= RESP;
        end
        RESP: if (bus.rsp_ready[r_grant]) begin
          r_ptr   <= (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
          r_ops   <= r_ops + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
